ssr_interrogation_ctrl: RTL and testbench

//  Sequences the SSR Mode A/C reply decoder across interrogation periods. Issues the tx trigger and

---
 rtl/ssr_interrogation_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ssr_interrogation_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssr_interrogation_ctrl.sv
// ssr_interrogation_ctrl
// Sequences the SSR Mode A/C reply decoder across interrogation periods.
// Each period fires a one-cycle tx_trig carrying the interlaced mode, waits
// out a dead time, then holds rx_sync high over the listen window. Rising
// edges of the decoder's valid inside the capture window are queued as
// reply reports in a small first-word-fall-through FIFO.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   enable          run interrogation periods while high
//   tx_trig         one-cycle transmit pulse
//   tx_mode         mode of the current period (0 = Mode A, 1 = Mode C)
//   rx_sync         listen-window gate to the decoder
//   dec_valid       decoder reply valid (may be high for several cycles)
//   dec_a..dec_d    decoder code groups
//   dec_rg          decoder range
//   rpt_valid       report FIFO not empty
//   rpt_ready       downstream accept; pops on rpt_valid & rpt_ready
//   rpt_code        {A,B,C,D} of the head entry
//   rpt_range       range of the head entry
//   rpt_mode        tx_mode at capture
//   rpt_seq         interrogation sequence number at capture
//   busy            controller is not idle
//   drop_cnt        replies lost to a full FIFO, saturating at 255
module ssr_interrogation_ctrl #(
  parameter int          PRF_PERIOD   = 400,
  parameter int          DEAD_LEN     = 16,
  parameter int          LISTEN_LEN   = 300,
  parameter int          PATTERN_LEN  = 2,
  parameter logic [7:0]  MODE_PATTERN = 8'h02,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        tx_trig,
  output logic        tx_mode,
  output logic        rx_sync,
  input  logic        dec_valid,
  input  logic [2:0]  dec_a,
  input  logic [2:0]  dec_b,
  input  logic [2:0]  dec_c,
  input  logic [2:0]  dec_d,
  input  logic [19:0] dec_rg,
  output logic        rpt_valid,
  input  logic        rpt_ready,
  output logic [11:0] rpt_code,
  output logic [19:0] rpt_range,
  output logic        rpt_mode,
  output logic [7:0]  rpt_seq,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2(PRF_PERIOD);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Period-counter values at which the FSM changes phase.
  localparam logic [CW-1:0] DEAD_END   = CW'(DEAD_LEN);
  localparam logic [CW-1:0] LISTEN_END = CW'(DEAD_LEN + LISTEN_LEN);
  localparam logic [CW-1:0] FIRST_HOLD = CW'(DEAD_LEN + LISTEN_LEN + 1);
  localparam logic [CW-1:0] PERIOD_END = CW'(PRF_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, TX, DEAD, LISTEN, HOLD} state_t;

  typedef struct packed {
    logic [11:0] code;
    logic [19:0] rg;
    logic        mode;
    logic [7:0]  seq;
  } entry_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      seq;
  logic            dec_valid_q;

  logic            period_end;
  logic            start;
  logic            in_window;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_ok;

  entry_t          mem [FIFO_DEPTH];
  entry_t          last_head;
  entry_t          head;
  entry_t          new_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;

  // The capture window extends one cycle into HOLD because the decoder's
  // valid lags rx_sync by a register stage.
  always_comb begin
    period_end = (state == HOLD) && (cnt == PERIOD_END);
    start      = enable && ((state == IDLE) || period_end);
    in_window  = (state == LISTEN) || ((state == HOLD) && (cnt == FIRST_HOLD));
    push       = in_window && dec_valid && !dec_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      seq     <= '0;
      tx_trig <= 1'b0;
      tx_mode <= 1'b0;
      rx_sync <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tx_trig <= 1'b0;
      if (start) begin
        state   <= TX;
        cnt     <= '0;
        tx_trig <= 1'b1;
        tx_mode <= MODE_PATTERN[idx];
        seq     <= seq + 8'd1;
        idx     <= (idx == 3'(PATTERN_LEN - 1)) ? 3'd0 : idx + 3'd1;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          TX: begin
            state <= DEAD;
            cnt   <= cnt + CW'(1);
          end
          DEAD: begin
            cnt <= cnt + CW'(1);
            if (cnt == DEAD_END) begin
              state   <= LISTEN;
              rx_sync <= 1'b1;
            end
          end
          LISTEN: begin
            cnt <= cnt + CW'(1);
            if (cnt == LISTEN_END) begin
              state   <= HOLD;
              rx_sync <= 1'b0;
            end
          end
          HOLD: begin
            if (period_end) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state   <= IDLE;
            rx_sync <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Cleared in TX so a valid still high from the previous period cannot
  // masquerade as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_valid_q <= 1'b0;
    else     dec_valid_q <= (state == TX) ? 1'b0 : dec_valid;
  end

  always_comb begin
    new_entry = {dec_a, dec_b, dec_c, dec_d, dec_rg, tx_mode, seq};
    rpt_valid = (count != '0);
    pop       = rpt_valid && rpt_ready;
    full      = (count == (AW + 1)'(FIFO_DEPTH));
    push_ok   = push && (!full || pop);
    // When empty the outputs keep showing the most recently popped entry.
    head      = rpt_valid ? mem[rd_ptr] : last_head;
    rpt_code  = head.code;
    rpt_range = head.rg;
    rpt_mode  = head.mode;
    rpt_seq   = head.seq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      last_head <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        last_head <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
      if (push && !push_ok && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ssr_interrogation_ctrl.sv
// tb_ssr_interrogation_ctrl
// Self-checking bench for ssr_interrogation_ctrl with a short interrogation
// period. Expected reports are queued when a decoder edge is driven and are
// compared as the DUT presents them on the report interface.
module tb_ssr_interrogation_ctrl;

  localparam int         PRF    = 40;
  localparam int         DEAD   = 3;
  localparam int         LISTEN = 20;
  localparam logic [7:0] MODES  = 8'h02;

  typedef struct packed {
    logic [11:0] code;
    logic [19:0] rg;
    logic        mode;
    logic [7:0]  seq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tx_trig;
  logic        tx_mode;
  logic        rx_sync;
  logic        dec_valid;
  logic [2:0]  dec_a, dec_b, dec_c, dec_d;
  logic [19:0] dec_rg;
  logic        rpt_valid;
  logic        rpt_ready;
  logic [11:0] rpt_code;
  logic [19:0] rpt_range;
  logic        rpt_mode;
  logic [7:0]  rpt_seq;
  logic        busy;
  logic [7:0]  drop_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got_e;

  ssr_interrogation_ctrl #(
    .PRF_PERIOD(PRF), .DEAD_LEN(DEAD), .LISTEN_LEN(LISTEN),
    .PATTERN_LEN(2), .MODE_PATTERN(MODES), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tx_trig(tx_trig), .tx_mode(tx_mode), .rx_sync(rx_sync),
    .dec_valid(dec_valid), .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c), .dec_d(dec_d),
    .dec_rg(dec_rg), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_code(rpt_code), .rpt_range(rpt_range), .rpt_mode(rpt_mode), .rpt_seq(rpt_seq),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted report must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected got code=%o rg=%0d mode=%0d seq=%0d",
                 rpt_code, rpt_range, rpt_mode, rpt_seq);
      end else begin
        got_e = sb.pop_front();
        if ({rpt_code, rpt_range, rpt_mode, rpt_seq} !== got_e) begin
          errors++;
          $display("[TB] FAIL sb_entry got code=%o rg=%0d mode=%0d seq=%0d want code=%o rg=%0d mode=%0d seq=%0d",
                   rpt_code, rpt_range, rpt_mode, rpt_seq,
                   got_e.code, got_e.rg, got_e.mode, got_e.seq);
        end
      end
    end
  end

  // Bench model of the capture window: cycle c relative to enable going
  // high at cycle 0, with np periods run.
  function automatic bit in_win(int c, int np);
    int p, o;
    if (c < 1) return 1'b0;
    p = (c - 1) / PRF;
    o = (c - 1) % PRF;
    return (p < np) && (o >= DEAD + 1) && (o <= DEAD + LISTEN + 1);
  endfunction

  // Leaves the bench at posedge+1 with everything idle; that instant is cycle 0.
  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; dec_valid = 1'b0; rpt_ready = 1'b0;
    dec_a = '0; dec_b = '0; dec_c = '0; dec_d = '0; dec_rg = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_trig, tx_mode, rx_sync, rpt_valid, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b want 00000", {tx_trig, tx_mode, rx_sync, rpt_valid, busy});
    end
    checks++;
    if ({rpt_code, rpt_range, rpt_mode, rpt_seq, drop_cnt} !== 49'd0) begin
      errors++;
      $display("[TB] FAIL reset_rpt got %h want 0", {rpt_code, rpt_range, rpt_mode, rpt_seq, drop_cnt});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Runs with enable high for cycles < off, a 3-cycle decoder valid at
  // period offset vo, and checks pulse timing every cycle.
  task automatic test_period_run(input int off, input int total, input int vo);
    int  np;
    bit  prev;
    logic [2:0] want;
    do_reset();
    np = (off + PRF - 1) / PRF;
    prev = 1'b0;
    rpt_ready = 1'b1;
    for (int c = 0; c < total; c++) begin
      int p, o;
      p = (c >= 1) ? (c - 1) / PRF : 0;
      o = (c >= 1) ? (c - 1) % PRF : -1;
      enable    = (c < off);
      dec_valid = (o >= vo) && (o <= vo + 2);
      dec_a  = 3'(5 + p);
      dec_b  = 3'(3 + p);
      dec_c  = 3'(p);
      dec_d  = 3'(7 - p);
      dec_rg = 20'(1234 + p);
      if (dec_valid && !prev && in_win(c, np))
        sb.push_back({dec_a, dec_b, dec_c, dec_d, dec_rg, MODES[p % 2], 8'(p + 1)});
      prev = dec_valid;
      want[2] = (c >= 1) && (o == 0) && (p < np);
      want[1] = (c >= 1) && (p < np) && (o >= DEAD + 1) && (o <= DEAD + LISTEN);
      want[0] = (c >= 1) && (c <= PRF * np);
      @(negedge clk);
      checks++;
      if ({tx_trig, rx_sync, busy} !== want) begin
        errors++;
        $display("[TB] FAIL timing c=%0d got trig/sync/busy=%b want %b", c, {tx_trig, rx_sync, busy}, want);
      end
      if (want[2]) begin
        checks++;
        if (tx_mode !== MODES[p % 2]) begin
          errors++;
          $display("[TB] FAIL tx_mode c=%0d got %0d want %0d", c, tx_mode, MODES[p % 2]);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL run_missing got %0d pending want 0", sb.size());
    end
  endtask

  // Seven one-cycle pulses with the consumer stalled: four fill the FIFO,
  // two are dropped, the seventh coincides with the first pop.
  task automatic test_drop();
    do_reset();
    for (int c = 0; c < 32; c++) begin
      int k;
      enable    = (c < 1);
      rpt_ready = (c >= 18);
      dec_valid = (c >= 6) && (c <= 18) && (c % 2 == 0);
      k = (c - 6) / 2;
      dec_a  = 3'(k);
      dec_b  = 3'(7 - k);
      dec_c  = 3'd2;
      dec_d  = 3'd1;
      dec_rg = 20'(100 + k);
      if (dec_valid && (k < 4 || k == 6))
        sb.push_back({dec_a, dec_b, dec_c, dec_d, dec_rg, 1'b0, 8'd1});
      @(negedge clk);
      if (c == 17) begin
        checks++;
        if ({rpt_valid, drop_cnt} !== {1'b1, 8'd2}) begin
          errors++;
          $display("[TB] FAIL drop_full got valid=%0d drops=%0d want valid=1 drops=2", rpt_valid, drop_cnt);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({rpt_valid, drop_cnt} !== {1'b0, 8'd2}) begin
      errors++;
      $display("[TB] FAIL drop_after got valid=%0d drops=%0d want valid=0 drops=2", rpt_valid, drop_cnt);
    end
    checks++;
    if ({rpt_code, rpt_range} !== {3'd6, 3'd1, 3'd2, 3'd1, 20'd106}) begin
      errors++;
      $display("[TB] FAIL hold_head got code=%o rg=%0d want code=6121 rg=106", rpt_code, rpt_range);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drop_missing got %0d pending want 0", sb.size());
    end
  endtask

  // Single-cycle pulses around the window edges over two periods.
  task automatic test_window();
    do_reset();
    rpt_ready = 1'b1;
    for (int c = 0; c < 86; c++) begin
      enable    = (c < 41);
      dec_valid = (c == 3) || (c == 26) || (c == 44) || (c == 46) || (c == 65) || (c == 67);
      dec_a = 3'(c % 8); dec_b = 3'd4; dec_c = 3'd4; dec_d = 3'd4;
      dec_rg = 20'(c);
      if (dec_valid && in_win(c, 2))
        sb.push_back({dec_a, dec_b, dec_c, dec_d, dec_rg, MODES[((c - 1) / PRF) % 2], 8'((c - 1) / PRF + 1)});
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL window_missing got %0d pending want 0", sb.size());
    end
    checks++;
    if (drop_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL window_drops got %0d want 0", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      enable    = 1'b1;
      dec_valid = (c == 10);
      dec_rg    = 20'd77;
      @(posedge clk); #1;
    end
    checks++;
    if ({rx_sync, rpt_valid, busy} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL pre_rst got sync/valid/busy=%b want 111", {rx_sync, rpt_valid, busy});
    end
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if ({tx_trig, rx_sync, rpt_valid, busy, drop_cnt} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL async_rst got trig/sync/valid/busy=%b drops=%0d want 0000 0",
               {tx_trig, rx_sync, rpt_valid, busy}, drop_cnt);
    end
    enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_period_run(130, 166, 10);
    test_period_run(50, 90, 21);
    test_drop();
    test_window();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
